// File: rtl/spk_out.sv
// spk_out: spike output stage behind soma.
// Queues fired neuron indices in a small FIFO. For each queued spike it walks
// the destination table and emits one flit per valid entry to the router.
// Optional feature: define SPK_OUT_CNT_EN to add a 32-bit accepted-flit counter.
module spk_out #(
    parameter int             FW        = 59,
    parameter int             FTW       = 3,
    parameter int             NNW       = 12,
    parameter int             SW        = 24,
    parameter int             DST_WIDTH = 21,
    parameter int             DST_DEPTH = 4,
    parameter int             QD        = 8,
    parameter logic [FTW-1:0] SPK_TYPE  = 3'b010
) (
    input  logic                         clk_spk_out,
    input  logic                         rst_n,
    input  logic                         soma_spk_out_fire,
    input  logic [NNW-1:0]               soma_spk_out_addr,
    input  logic                         config_spk_out_enable,
    input  logic [SW-1:0]                config_spk_out_spk_base,
    input  logic                         config_spk_out_dst_we,
    input  logic [$clog2(DST_DEPTH)-1:0] config_spk_out_dst_waddr,
    input  logic [DST_WIDTH-1:0]         config_spk_out_dst_wdata,
    output logic [FW-1:0]                spk_out_flit,
    output logic                         spk_out_vld,
    input  logic                         router_spk_out_rdy,
    output logic                         spk_out_busy,
`ifdef SPK_OUT_CNT_EN
    output logic [31:0]                  spk_out_cnt,
`endif
    output logic                         spk_out_ovf
);

    localparam int AW   = $clog2(DST_DEPTH);
    localparam int QAW  = $clog2(QD);
    localparam int PADW = FW - FTW - DST_WIDTH - SW;
    localparam logic [QAW:0]  QD_COUNT = (QAW + 1)'(QD);
    localparam logic [AW-1:0] LAST_IDX = AW'(DST_DEPTH - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t               state;
    state_t               next_state;

    logic [NNW-1:0]       fifo_mem [QD];
    logic [QAW-1:0]       wr_ptr;
    logic [QAW-1:0]       rd_ptr;
    logic [QAW:0]         count;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fire_req;
    logic                 push;
    logic                 pop;

    logic [DST_WIDTH-1:0] dst_tbl [DST_DEPTH];
    logic [DST_WIDTH-1:0] cur_ent;
    logic [NNW-1:0]       cur_addr;
    logic [AW-1:0]        dst_idx;
    logic                 advance;
    logic [SW-1:0]        payload;

    // Full/empty are judged on the pre-edge count, so a full FIFO drops a fire
    // even when a pop happens in the same cycle.
    assign fifo_full  = (count == QD_COUNT);
    assign fifo_empty = (count == '0);
    assign fire_req   = soma_spk_out_fire && config_spk_out_enable;
    assign push       = fire_req && !fifo_full;

    assign cur_ent     = dst_tbl[dst_idx];
    assign spk_out_vld = (state == SEND) && cur_ent[0];
    assign advance     = (state == SEND) && (!cur_ent[0] || router_spk_out_rdy);
    assign payload     = config_spk_out_spk_base + {{(SW-NNW){1'b0}}, cur_addr};

    // Flit is held at zero outside a valid beat so reset leaves every output at 0.
    assign spk_out_flit = spk_out_vld ? {SPK_TYPE, cur_ent, payload, {PADW{1'b0}}} : '0;
    assign spk_out_busy = !fifo_empty || (state != IDLE);

    // FIFO storage; contents need no reset because the pointers and count do.
    always_ff @(posedge clk_spk_out) begin
        if (push) begin
            fifo_mem[wr_ptr] <= soma_spk_out_addr;
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk_spk_out or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            spk_out_ovf <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + QAW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + QAW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (QAW + 1)'(1);
                2'b01:   count <= count - (QAW + 1)'(1);
                default: count <= count;
            endcase
            if (fire_req && fifo_full) begin
                spk_out_ovf <= 1'b1;
            end
        end
    end

    // Destination table: writes land at the clock edge, reset marks all invalid.
    always_ff @(posedge clk_spk_out or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DST_DEPTH; i++) begin
                dst_tbl[i] <= '0;
            end
        end else if (config_spk_out_dst_we) begin
            dst_tbl[config_spk_out_dst_waddr] <= config_spk_out_dst_wdata;
        end
    end

    // FSM state register plus the in-flight spike and table walk index.
    always_ff @(posedge clk_spk_out or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cur_addr <= '0;
            dst_idx  <= '0;
        end else begin
            state <= next_state;
            if (pop) begin
                cur_addr <= fifo_mem[rd_ptr];
                dst_idx  <= '0;
            end else if (advance) begin
                dst_idx <= dst_idx + AW'(1);
            end
        end
    end

    // Next-state and pop decision; back-to-back spikes pop straight from SEND.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_state = SEND;
                end
            end
            SEND: begin
                if (advance && (dst_idx == LAST_IDX)) begin
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

`ifdef SPK_OUT_CNT_EN
    logic [31:0] cnt_q;

    // Counts accepted flits; wraps naturally and ignores enable.
    always_ff @(posedge clk_spk_out or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (spk_out_vld && router_spk_out_rdy) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign spk_out_cnt = cnt_q;
`endif

endmodule
